// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the IF-stage PC sequencer:
// next-PC select encodings and default reset/exception addresses.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ     = 3'd0,
        NPC_BRANCH  = 3'd1,
        NPC_JUMP    = 3'd2,
        NPC_JUMPREG = 3'd3,
        NPC_JAL     = 3'd4,
        NPC_JRRA    = 3'd5
    } npcSel_e;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam int          RAS_DEPTH_DEF  = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the pipeline control (D / M stages) and the
// PC sequencer: redirect inputs in, fetch PC and RAS status out.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int SEL_W  = 3
);
    logic              istall;
    logic [SEL_W-1:0]  iNPC_sel;
    logic [ADDR_W-1:0] iD_PC;
    logic [31:0]       iinstr;
    logic [ADDR_W-1:0] irs;
    logic              iexc;
    logic              ieret;
    logic [ADDR_W-1:0] iepc;
    logic [ADDR_W-1:0] oPC;
    logic [ADDR_W-1:0] oPC8;
    logic [ADDR_W-1:0] oras_top;
    logic              oras_valid;
    logic              oras_mispred;
    logic              oadel;

    modport master (
        output istall, iNPC_sel, iD_PC, iinstr, irs,
        output iexc, ieret, iepc,
        input  oPC, oPC8, oras_top, oras_valid,
        input  oras_mispred, oadel
    );

    modport slave (
        input  istall, iNPC_sel, iD_PC, iinstr, irs,
        input  iexc, ieret, iepc,
        output oPC, oPC8, oras_top, oras_valid,
        output oras_mispred, oadel
    );

endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: a push when full overwrites
// the oldest entry, a pop when empty is ignored.
module ras_stack #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pushAddr,
    output logic [ADDR_W-1:0] top,
    output logic              valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PW-1:0]     ptr;
    logic [CW-1:0]     count;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else if (push) begin
            mem[ptr] <= pushAddr;
            ptr      <= ptr + PW'(1);
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop && count != '0) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

    // ptr names the next free slot; the newest entry sits just below it
    assign top   = mem[ptr - PW'(1)];
    assign valid = (count != '0);

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage PC register with prioritised redirect mux
// and a return-address stack for jal / jr $ra.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF),
    parameter int                RAS_DEPTH  = RAS_DEPTH_DEF,
    parameter int                SEL_W      = 3
) (
    input logic            iclk,
    input logic            ireset_n,
    pc_sequencer_if.slave  bus
);
    logic [ADDR_W-1:0] pcQ;
    logic [ADDR_W-1:0] pcNext;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] branchTgt;
    logic [ADDR_W-1:0] jumpTgt;
    logic [ADDR_W-1:0] rasTop;
    logic              adelQ;
    logic              rasValid;
    logic              rasUpdate;
    logic              isBranch;
    logic              isJump;
    logic              isJumpReg;
    logic              isJal;
    logic              isJrra;
    logic [5:0]        unusedOpcode;

    assign unusedOpcode = bus.iinstr[31:26];

    always_comb begin
        isBranch  = 1'b0;
        isJump    = 1'b0;
        isJumpReg = 1'b0;
        isJal     = 1'b0;
        isJrra    = 1'b0;
        case (bus.iNPC_sel)
            SEL_W'(NPC_BRANCH):  isBranch  = 1'b1;
            SEL_W'(NPC_JUMP):    isJump    = 1'b1;
            SEL_W'(NPC_JUMPREG): isJumpReg = 1'b1;
            SEL_W'(NPC_JAL):     isJal     = 1'b1;
            SEL_W'(NPC_JRRA):    isJrra    = 1'b1;
            default: ;
        endcase
    end

    assign offset = {{(ADDR_W-18){bus.iinstr[15]}},
                     bus.iinstr[15:0], 2'b00};
    assign branchTgt = bus.iD_PC + ADDR_W'(4) + offset;
    assign jumpTgt = {bus.iD_PC[ADDR_W-1:28],
                      bus.iinstr[25:0], 2'b00};

    always_comb begin
        pcNext = pcQ + ADDR_W'(4);
        if (bus.iexc) begin
            pcNext = EXC_VECTOR;
        end else if (bus.ieret) begin
            pcNext = bus.iepc;
        end else if (bus.istall) begin
            pcNext = pcQ;
        end else if (isBranch) begin
            pcNext = branchTgt;
        end else if (isJump || isJal) begin
            pcNext = jumpTgt;
        end else if (isJumpReg || isJrra) begin
            pcNext = bus.irs;
        end
    end

    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            pcQ   <= RESET_PC;
            adelQ <= 1'b0;
        end else begin
            pcQ   <= pcNext;
            adelQ <= (pcNext[1:0] != 2'b00);
        end
    end

    // eret and stall both leave the stack untouched
    assign rasUpdate = !bus.iexc && !bus.ieret && !bus.istall;

    ras_stack #(
        .DEPTH  (RAS_DEPTH),
        .ADDR_W (ADDR_W)
    ) uRas (
        .clk      (iclk),
        .rstN     (ireset_n),
        .push     (rasUpdate && isJal),
        .pop      (rasUpdate && isJrra),
        .flush    (bus.iexc),
        .pushAddr (bus.iD_PC + ADDR_W'(8)),
        .top      (rasTop),
        .valid    (rasValid)
    );

    assign bus.oPC          = pcQ;
    assign bus.oPC8         = bus.iD_PC + ADDR_W'(8);
    assign bus.oras_top     = rasTop;
    assign bus.oras_valid   = rasValid;
    assign bus.oras_mispred = isJrra &&
                              (!rasValid || rasTop != bus.irs);
    assign bus.oadel        = adelQ;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and random stimulus for pc_sequencer, checked
// against a queue-based reference model of PC and RAS.
module tb_pc_sequencer;

    localparam int DEPTH = 4;

    logic clk;
    logic rstN;
    int   nAsserts;
    int   nFails;

    logic [31:0] mPc;
    logic        mAdel;
    logic [31:0] mRas[$];

    pc_sequencer_if #(.ADDR_W(32), .SEL_W(3)) bus ();

    pc_sequencer #(
        .ADDR_W     (32),
        .RESET_PC   (32'h0000_3000),
        .EXC_VECTOR (32'h0000_4180),
        .RAS_DEPTH  (DEPTH),
        .SEL_W      (3)
    ) dut (
        .iclk     (clk),
        .ireset_n (rstN),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelEdge(input logic r, st,
                             input logic [2:0] sel,
                             input logic [31:0] dpc, ins, rs,
                             input logic ex, er,
                             input logic [31:0] ep);
        int off;
        if (!r) begin
            mPc = 32'h3000;
            mRas.delete();
        end else if (ex) begin
            mPc = 32'h4180;
            mRas.delete();
        end else if (er) begin
            mPc = ep;
        end else if (!st) begin
            case (sel)
                3'd1: begin
                    off = int'($signed(ins[15:0]));
                    mPc = dpc + 32'd4 + 32'(off * 4);
                end
                3'd2, 3'd4:
                    mPc = (dpc & 32'hF000_0000) |
                          ((ins & 32'h03FF_FFFF) << 2);
                3'd3, 3'd5: mPc = rs;
                default: mPc = mPc + 32'd4;
            endcase
            if (sel == 3'd4) begin
                mRas.push_back(dpc + 32'd8);
                if (mRas.size() > DEPTH) void'(mRas.pop_front());
            end else if (sel == 3'd5 && mRas.size() > 0) begin
                void'(mRas.pop_back());
            end
        end
        mAdel = r && (mPc[1:0] != 2'b00);
    endtask

    task automatic step(input logic r, st,
                        input logic [2:0] sel,
                        input logic [31:0] dpc, ins, rs,
                        input logic ex, er,
                        input logic [31:0] ep);
        logic expMis;
        rstN         = r;
        bus.istall   = st;
        bus.iNPC_sel = sel;
        bus.iD_PC    = dpc;
        bus.iinstr   = ins;
        bus.irs      = rs;
        bus.iexc     = ex;
        bus.ieret    = er;
        bus.iepc     = ep;
        #2;
        expMis = (sel == 3'd5) &&
                 (mRas.size() == 0 || mRas[$] != rs);
        chk("oPC_hold", bus.oPC, mPc);
        chk("oPC8", bus.oPC8, dpc + 32'd8);
        chk("mispred", 32'(bus.oras_mispred), 32'(expMis));
        chk("rasValid", 32'(bus.oras_valid), 32'(mRas.size() > 0));
        if (mRas.size() > 0) chk("rasTop", bus.oras_top, mRas[$]);
        @(posedge clk);
        modelEdge(r, st, sel, dpc, ins, rs, ex, er, ep);
        #1;
        chk("oPC", bus.oPC, mPc);
        chk("oadel", 32'(bus.oadel), 32'(mAdel));
    endtask

    initial begin
        logic [31:0] rs;
        nAsserts = 0;
        nFails   = 0;
        rstN = 1'b0;
        bus.istall = 1'b0; bus.iNPC_sel = 3'd0;
        bus.iD_PC = 32'h3000; bus.iinstr = '0; bus.irs = '0;
        bus.iexc = 1'b0; bus.ieret = 1'b0; bus.iepc = '0;
        @(posedge clk);
        #1;
        mPc = 32'h3000; mAdel = 1'b0;
        chk("reset_pc", bus.oPC, 32'h3000);
        chk("reset_adel", 32'(bus.oadel), 32'd0);
        chk("reset_valid", 32'(bus.oras_valid), 32'd0);

        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 3'd0, 32'h3000, 0, 0, 0, 0, 0);
            chk("seq_pc", bus.oPC, 32'h3000 + 32'(4 * i));
            chk("seq_adel", 32'(bus.oadel), 32'd0);
        end

        step(1, 0, 3'd1, 32'h3010, 32'h0000_FFFC, 0, 0, 0, 0);
        chk("branch_neg", bus.oPC, 32'h3004);
        step(1, 0, 3'd1, 32'h3010, 32'h0000_0002, 0, 0, 0, 0);
        chk("branch_pos", bus.oPC, 32'h301C);

        for (int i = 0; i < 2; i++) begin
            step(1, 1, 3'd1, 32'h3010, 32'h0000_FFFC, 0, 0, 0, 0);
            chk("stall_hold", bus.oPC, 32'h301C);
        end
        step(1, 0, 3'd1, 32'h3010, 32'h0000_FFFC, 0, 0, 0, 0);
        chk("stall_release", bus.oPC, 32'h3004);

        for (int i = 0; i < 5; i++)
            step(1, 0, 3'd4, 32'h3000 + 32'(i * 'h100),
                 32'h0000_0C00, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("jrra_top", bus.oras_top, 32'h3408 - 32'(i * 'h100));
            step(1, 0, 3'd5, 32'h3000, 0,
                 32'h3408 - 32'(i * 'h100), 0, 0, 0);
        end
        chk("ras_empty", 32'(bus.oras_valid), 32'd0);
        bus.iNPC_sel = 3'd5; bus.irs = 32'h3008;
        #1;
        chk("empty_mispred", 32'(bus.oras_mispred), 32'd1);
        step(1, 0, 3'd5, 32'h3000, 0, 32'h3008, 0, 0, 0);

        step(1, 0, 3'd4, 32'h3200, 32'h0000_0C00, 0, 0, 0, 0);
        step(1, 1, 3'd2, 32'h3000, 32'h0000_0C00, 0, 1, 0, 0);
        chk("exc_pc", bus.oPC, 32'h4180);
        chk("exc_flush", 32'(bus.oras_valid), 32'd0);
        step(1, 0, 3'd0, 32'h3000, 0, 0, 0, 1, 32'h3020);
        chk("eret_pc", bus.oPC, 32'h3020);

        step(1, 0, 3'd3, 32'h3000, 0, 32'h3002, 0, 0, 0);
        chk("jr_pc", bus.oPC, 32'h3002);
        chk("jr_adel", 32'(bus.oadel), 32'd1);
        step(0, 0, 3'd2, 32'h3000, 0, 0, 1, 0, 0);
        chk("rst_pc", bus.oPC, 32'h3000);
        chk("rst_adel", 32'(bus.oadel), 32'd0);

        for (int n = 0; n < 400; n++) begin
            rs = $urandom;
            if (($urandom % 2) == 0 && mRas.size() > 0) rs = mRas[$];
            step(($urandom % 50) != 0,
                 ($urandom % 6) == 0,
                 3'($urandom_range(0, 7)),
                 $urandom & 32'hFFFF_FFFC,
                 $urandom,
                 rs,
                 ($urandom % 25) == 0,
                 ($urandom % 25) == 0,
                 $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAsserts, nFails);
        $finish;
    end

endmodule
